// File: rtl/dffcl_seq_pkg.sv
// Shared types and widths for the dffcl op sequencer and its command FIFO.
package dffcl_seq_pkg;

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned MODE_W    = 4;
    localparam int unsigned SEQ_TAG_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } seq_state_e;

    // Queued command; the tag field carries up to SEQ_TAG_W bits of the opaque tag.
    typedef struct packed {
        logic [DATA_W-1:0]    in1;
        logic [DATA_W-1:0]    in2;
        logic [MODE_W-1:0]    mode;
        logic [SEQ_TAG_W-1:0] tag;
    } seq_cmd_t;

endpackage

// File: rtl/dffcl_seq_fifo.sv
// Command FIFO: no fall-through, pointers wrap via an extra MSB, full/empty registered.
module dffcl_seq_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             dffcl_clk,
    input  logic             dffcl_rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data_c,
    output logic             not_full,
    output logic             empty,
    output logic             empty_nxt_c
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
    logic             push_c, pop_c, full_nxt_c;

    assign push_c    = push && not_full;
    assign pop_c     = pop && !empty;
    assign rd_data_c = mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d    = wr_ptr_q + (AW+1)'(push_c);
        rd_ptr_d    = rd_ptr_q + (AW+1)'(pop_c);
        empty_nxt_c = (wr_ptr_d == rd_ptr_d);
        full_nxt_c  = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                      (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    always_ff @(posedge dffcl_clk or negedge dffcl_rst_n) begin
        if (!dffcl_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            not_full <= 1'b1;
            empty    <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            not_full <= !full_nxt_c;
            empty    <= empty_nxt_c;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge dffcl_clk) begin
        if (push_c) mem[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/dffcl_op_sequencer.sv
// Issues queued commands to the dffcl ALU stage one at a time and returns {result, tag}.
// Optional DFFCL_SEQ_PARITY_EN adds a registered even-parity output resp_parity.
module dffcl_op_sequencer
    import dffcl_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic              dffcl_clk,
    input  logic              dffcl_rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [15:0]       cmd_in1,
    input  logic [15:0]       cmd_in2,
    input  logic [3:0]        cmd_mode,
    input  logic [TAG_W-1:0]  cmd_tag,
    output logic [15:0]       stg_data_in1,
    output logic [15:0]       stg_data_in2,
    output logic [3:0]        stg_ctrl_mode,
    input  logic [15:0]       stg_data_out,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [15:0]       resp_data,
    output logic [TAG_W-1:0]  resp_tag,
    output logic [CNT_W-1:0]  issue_cnt,
    output logic              busy
`ifdef DFFCL_SEQ_PARITY_EN
    ,
    output logic              resp_parity
`endif
);

    localparam int unsigned CMD_W = $bits(seq_cmd_t);

    seq_state_e       state_q, state_d;
    seq_cmd_t         wr_cmd_c, rd_cmd_c;
    logic [CMD_W-1:0] rd_word_c;
    logic [TAG_W-1:0] tag_q;
    logic             fifo_empty, fifo_empty_nxt_c;
    logic             pop_c, capt_c, resp_hs_c;

    always_comb begin
        wr_cmd_c      = '0;
        wr_cmd_c.in1  = cmd_in1;
        wr_cmd_c.in2  = cmd_in2;
        wr_cmd_c.mode = cmd_mode;
        wr_cmd_c.tag  = SEQ_TAG_W'(cmd_tag);
    end

    assign rd_cmd_c = seq_cmd_t'(rd_word_c);

    dffcl_seq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .dffcl_clk   (dffcl_clk),
        .dffcl_rst_n (dffcl_rst_n),
        .push        (cmd_valid),
        .wr_data     (CMD_W'(wr_cmd_c)),
        .pop         (pop_c),
        .rd_data_c   (rd_word_c),
        .not_full    (cmd_ready),
        .empty       (fifo_empty),
        .empty_nxt_c (fifo_empty_nxt_c)
    );

    always_ff @(posedge dffcl_clk or negedge dffcl_rst_n) begin
        if (!dffcl_rst_n) state_q <= IDLE;
        else              state_q <= state_d;
    end

    // Next state and one-cycle strobes; a response handshake may pop the next command.
    always_comb begin
        state_d   = state_q;
        pop_c     = 1'b0;
        capt_c    = 1'b0;
        resp_hs_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop_c   = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: state_d = CAPT;
            CAPT: begin
                capt_c  = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    resp_hs_c = 1'b1;
                    if (!fifo_empty) begin
                        pop_c   = 1'b1;
                        state_d = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge dffcl_clk or negedge dffcl_rst_n) begin
        if (!dffcl_rst_n) begin
            stg_data_in1  <= '0;
            stg_data_in2  <= '0;
            stg_ctrl_mode <= '0;
            tag_q         <= '0;
            resp_valid    <= 1'b0;
            resp_data     <= '0;
            resp_tag      <= '0;
            issue_cnt     <= '0;
            busy          <= 1'b0;
`ifdef DFFCL_SEQ_PARITY_EN
            resp_parity   <= 1'b0;
`endif
        end else begin
            busy <= (state_d != IDLE) || !fifo_empty_nxt_c;
            if (pop_c) begin
                stg_data_in1  <= rd_cmd_c.in1;
                stg_data_in2  <= rd_cmd_c.in2;
                stg_ctrl_mode <= rd_cmd_c.mode;
                tag_q         <= TAG_W'(rd_cmd_c.tag);
                issue_cnt     <= issue_cnt + CNT_W'(1);
            end
            if (capt_c) begin
                resp_valid  <= 1'b1;
                resp_data   <= stg_data_out;
                resp_tag    <= tag_q;
`ifdef DFFCL_SEQ_PARITY_EN
                resp_parity <= ^stg_data_out;
`endif
            end else if (resp_hs_c) begin
                resp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dffcl_op_sequencer.sv
// Directed bench for dffcl_op_sequencer with a behavioural ALU stage and a response scoreboard.
module tb_dffcl_op_sequencer;

    logic        clk, rst_n;
    logic        cmd_valid, cmd_ready;
    logic [15:0] cmd_in1, cmd_in2;
    logic [3:0]  cmd_mode, cmd_tag;
    logic [15:0] stg_in1, stg_in2, stg_out;
    logic [3:0]  stg_mode;
    logic        resp_valid, resp_ready;
    logic [15:0] resp_data;
    logic [3:0]  resp_tag;
    logic [7:0]  issue_cnt;
    logic        busy;
`ifdef DFFCL_SEQ_PARITY_EN
    logic        resp_parity;
`endif

    typedef struct {
        logic [15:0] data;
        logic [3:0]  tag;
    } exp_t;

    exp_t sb[$];
    int   hs_times[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc_n = 0;
    bit   accepted;
    int   got;

    dffcl_op_sequencer #(.DEPTH(4), .TAG_W(4), .CNT_W(8)) dut (
        .dffcl_clk     (clk),
        .dffcl_rst_n   (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_in1       (cmd_in1),
        .cmd_in2       (cmd_in2),
        .cmd_mode      (cmd_mode),
        .cmd_tag       (cmd_tag),
        .stg_data_in1  (stg_in1),
        .stg_data_in2  (stg_in2),
        .stg_ctrl_mode (stg_mode),
        .stg_data_out  (stg_out),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .resp_tag      (resp_tag),
        .issue_cnt     (issue_cnt),
        .busy          (busy)
`ifdef DFFCL_SEQ_PARITY_EN
        ,
        .resp_parity   (resp_parity)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] m);
        case (m)
            4'd0:    return a + b;
            4'd1:    return a & b;
            4'd2:    return a | b;
            4'd3:    return a ^ b;
            4'd4:    return a - b;
            4'd7:    return a;
            4'd8:    return b;
            default: return 16'h0000;
        endcase
    endfunction

    // Behavioural ALU stage: registered result, shares the sequencer reset.
    logic [15:0] alu_q;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) alu_q <= 16'h0;
        else        alu_q <= alu_ref(stg_in1, stg_in2, stg_mode);
    end
    assign stg_out = alu_q;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // One clock: observe handshakes at the falling edge, return 1 time unit after the rising edge.
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        cyc_n++;
        if (cmd_valid && cmd_ready) begin
            e.data = alu_ref(cmd_in1, cmd_in2, cmd_mode);
            e.tag  = cmd_tag;
            sb.push_back(e);
            accepted = 1'b1;
        end
        if (resp_valid && resp_ready) begin
            hs_times.push_back(cyc_n);
            if (sb.size() == 0) begin
                chk("unexpected_resp", 32'(resp_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("resp_data", 32'(resp_data), 32'(e.data));
                chk("resp_tag", 32'(resp_tag), 32'(e.tag));
`ifdef DFFCL_SEQ_PARITY_EN
                chk("resp_parity", 32'(resp_parity), 32'(^e.data));
`endif
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] m, input logic [3:0] t);
        cmd_in1   = a;
        cmd_in2   = b;
        cmd_mode  = m;
        cmd_tag   = t;
        cmd_valid = 1'b1;
        accepted  = 1'b0;
        for (int i = 0; i < 100 && !accepted; i++) cyc();
        if (!accepted) chk("send_timeout", 32'(accepted), 32'd1);
        cmd_valid = 1'b0;
    endtask

    task automatic load_rand(input int n);
        cmd_in1  = 16'($urandom);
        cmd_in2  = 16'($urandom);
        cmd_mode = 4'($urandom_range(0, 15));
        cmd_tag  = 4'(n);
    endtask

    // Hold cmd_valid until n commands are accepted or max_cyc cycles elapse.
    task automatic stream(input int n, input int max_cyc, output int cnt);
        cnt = 0;
        load_rand(0);
        cmd_valid = 1'b1;
        for (int i = 0; i < max_cyc && cnt < n; i++) begin
            accepted = 1'b0;
            cyc();
            if (accepted) begin
                cnt++;
                load_rand(cnt);
            end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 4000 && (busy || sb.size() != 0); i++) cyc();
        chk("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    task automatic reset_dut();
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        resp_ready = 1'b0;
        cyc();
        cyc();
        sb.delete();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_in1    = '0;
        cmd_in2    = '0;
        cmd_mode   = '0;
        cmd_tag    = '0;
        resp_ready = 1'b0;
        cyc();
        cyc();

        // Reset state
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_issue_cnt", 32'(issue_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_stg_in1", 32'(stg_in1), 32'd0);
        rst_n = 1'b1;
        cyc();

        // Add, with pop-to-valid latency of two cycles
        send(16'h0005, 16'h0003, 4'd0, 4'd1);
        cyc();
        chk("t1_stg_in1", 32'(stg_in1), 32'h5);
        chk("t1_stg_in2", 32'(stg_in2), 32'h3);
        chk("t1_issue_cnt", 32'(issue_cnt), 32'd1);
        chk("t1_valid_pop", 32'(resp_valid), 32'd0);
        cyc();
        chk("t1_valid_exec", 32'(resp_valid), 32'd0);
        cyc();
        chk("t1_valid_capt", 32'(resp_valid), 32'd1);
        chk("t1_data", 32'(resp_data), 32'h0008);
        chk("t1_tag", 32'(resp_tag), 32'd1);
        cyc();
        chk("t1_valid_held", 32'(resp_valid), 32'd1);
        resp_ready = 1'b1;
        cyc();
        chk("t1_valid_drop", 32'(resp_valid), 32'd0);

        // Logic modes and pass-through modes
        send(16'h000A, 16'h0003, 4'd1, 4'd2);
        send(16'h0000, 16'h1234, 4'd2, 4'd3);
        wait_idle();
        send(16'hBEEF, 16'h1111, 4'd7, 4'd4);
        send(16'hBEEF, 16'h1111, 4'd8, 4'd5);
        wait_idle();
        chk("t3_issue_cnt", 32'(issue_cnt), 32'd5);

        // Backpressure: FIFO plus issue slot absorb exactly DEPTH+1 commands
        resp_ready = 1'b0;
        stream(10, 12, got);
        chk("t4_accepted", 32'(got), 32'd5);
        chk("t4_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("t4_busy", 32'(busy), 32'd1);
        resp_ready = 1'b1;
        wait_idle();
        chk("t4_cmd_ready_after", 32'(cmd_ready), 32'd1);

        // Back-to-back throughput and counter wrap
        reset_dut();
        resp_ready = 1'b1;
        hs_times.delete();
        stream(3, 30, got);
        wait_idle();
        chk("t5_issue_cnt", 32'(issue_cnt), 32'd3);
        chk("t5_resp_count", 32'(hs_times.size()), 32'd3);
        if (hs_times.size() == 3) begin
            chk("t5_gap1", 32'(hs_times[1] - hs_times[0]), 32'd3);
            chk("t5_gap2", 32'(hs_times[2] - hs_times[1]), 32'd3);
        end
        stream(252, 2000, got);
        wait_idle();
        chk("t5_issue_255", 32'(issue_cnt), 32'd255);
        send(16'h0001, 16'h0001, 4'd0, 4'd6);
        wait_idle();
        chk("t5_issue_wrap", 32'(issue_cnt), 32'd0);

        // Reset while a command sits in CAPT and another is queued
        resp_ready = 1'b0;
        send(16'h0001, 16'h0002, 4'd0, 4'd5);
        send(16'h0003, 16'h0004, 4'd0, 4'd6);
        cyc();
        rst_n = 1'b0;
        #1;
        chk("t6_valid_rst", 32'(resp_valid), 32'd0);
        chk("t6_busy_rst", 32'(busy), 32'd0);
        chk("t6_ready_rst", 32'(cmd_ready), 32'd1);
        sb.delete();
        cyc();
        rst_n      = 1'b1;
        resp_ready = 1'b1;
        for (int i = 0; i < 10; i++) cyc();
        chk("t6_no_resp", 32'(resp_valid), 32'd0);
        chk("t6_busy_after", 32'(busy), 32'd0);

        // Result with odd bit count
        resp_ready = 1'b0;
        send(16'h0003, 16'h0004, 4'd0, 4'd9);
        for (int i = 0; i < 20 && !resp_valid; i++) cyc();
        chk("t7_data", 32'(resp_data), 32'h0007);
`ifdef DFFCL_SEQ_PARITY_EN
        chk("t7_parity", 32'(resp_parity), 32'd1);
`endif
        resp_ready = 1'b1;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
